// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Optional grant statistics are enabled with RAM_ARB_STATS_EN.
package ram_arb_pkg;

    localparam int DEF_AW = 3;
    localparam int DEF_DW = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT
    } arb_state_t;

    // Grant counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: with both requesting, the port that did not
// win last time is granted.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 & (~req1 | last_gnt);
    assign gnt1 = req1 & (~req0 | ~last_gnt);

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for two requesters in front of a single-port RAM.
// Define RAM_ARB_STATS_EN to add saturating per-port grant counters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_wr,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_wr,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          ram_en,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    arb_state_t    state;
    logic          last_gnt;
    logic          gnt0;
    logic          gnt1;
    logic          acc0;
    logic          acc1;
    logic          cmd_wr;
    logic          cmd_port;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req0     (req0_valid),
        .req1     (req1_valid),
        .last_gnt (last_gnt),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    assign req0_ready = (state == IDLE) && !rst && gnt0;
    assign req1_ready = (state == IDLE) && !rst && gnt1;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    assign sel_wr    = acc1 ? req1_wr    : req0_wr;
    assign sel_addr  = acc1 ? req1_addr  : req0_addr;
    assign sel_wdata = acc1 ? req1_wdata : req0_wdata;

    // The RAM address/data registers double as the command register, so the
    // access is already on the RAM pins in the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            cmd_wr     <= 1'b0;
            cmd_port   <= 1'b0;
            ram_en     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        cmd_wr    <= sel_wr;
                        cmd_port  <= acc1;
                        last_gnt  <= acc1;
                        ram_en    <= 1'b1;
                        ram_wr    <= sel_wr;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_en <= 1'b0;
                    ram_wr <= 1'b0;
                    state  <= cmd_wr ? IDLE : CAPT;
                end
                CAPT: begin
                    if (cmd_port) begin
                        rsp1_rdata <= ram_rdata;
                        rsp1_valid <= 1'b1;
                    end else begin
                        rsp0_rdata <= ram_rdata;
                        rsp0_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (acc0) gnt_cnt0 <= sat_inc(gnt_cnt0);
            if (acc1) gnt_cnt1 <= sat_inc(gnt_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 8x8 RAM.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_wr = 1'b0;
    logic [2:0] req0_addr = '0;
    logic [7:0] req0_wdata = '0;
    logic       req1_valid = 1'b0, req1_wr = 1'b0;
    logic [2:0] req1_addr = '0;
    logic [7:0] req1_wdata = '0;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       ram_en, ram_wr;
    logic [2:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
`ifdef RAM_ARB_STATS_EN
    logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:7];

    ram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_en     (ram_en),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef RAM_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM with a one-cycle registered read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task applyStimulus(input logic v0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic w1, input logic [2:0] a1, input logic [7:0] d1);
        req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
        #1;
    endtask

    task step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        int p;
        for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);

        // Reset state, with both ports requesting while reset is held
        rst = 1'b1;
        applyStimulus(1, 0, 3, 0, 1, 0, 4, 0);
        step; step;
        checkOutput("rst_ready0", req0_ready, 0);
        checkOutput("rst_ready1", req1_ready, 0);
        checkOutput("rst_ram_en", ram_en, 0);
        checkOutput("rst_ram_wr", ram_wr, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_wdata", ram_wdata, 0);
        checkOutput("rst_rsp0_valid", rsp0_valid, 0);
        checkOutput("rst_rsp1_valid", rsp1_valid, 0);
        checkOutput("rst_rsp0_rdata", rsp0_rdata, 0);
        checkOutput("rst_rsp1_rdata", rsp1_rdata, 0);

        // Port 0 writes 19 to addr 7, then reads it back
        rst = 1'b0;
        applyStimulus(1, 1, 7, 19, 0, 0, 0, 0);
        checkOutput("t1_ready0", req0_ready, 1);
        checkOutput("t1_ready1", req1_ready, 0);
        step;
        checkOutput("t1_wr_en", ram_en, 1);
        checkOutput("t1_wr_wr", ram_wr, 1);
        checkOutput("t1_wr_addr", ram_addr, 7);
        checkOutput("t1_wr_data", ram_wdata, 19);
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 0);
        checkOutput("t1_issue_ready0", req0_ready, 0);
        step;
        checkOutput("t1_idle_ready0", req0_ready, 1);
        checkOutput("t1_idle_ram_en", ram_en, 0);
        step;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rd_en", ram_en, 1);
        checkOutput("t1_rd_wr", ram_wr, 0);
        checkOutput("t1_rd_addr", ram_addr, 7);
        step;
        checkOutput("t1_capt_en", ram_en, 0);
        checkOutput("t1_capt_rsp0", rsp0_valid, 0);
        step;
        checkOutput("t1_rsp0_valid", rsp0_valid, 1);
        checkOutput("t1_rsp0_rdata", rsp0_rdata, 19);
        checkOutput("t1_rsp1_valid", rsp1_valid, 0);
        step;
        checkOutput("t1_rsp0_pulse_end", rsp0_valid, 0);
        checkOutput("t1_rsp0_hold", rsp0_rdata, 19);

        // Both ports hold reads after reset: strict alternation starting at port 0
        rst = 1'b1;
        step;
        rst = 1'b0;
        applyStimulus(1, 0, 6, 0, 1, 0, 5, 0);
        for (int i = 0; i < 8; i++) begin
            p = i % 2;
            checkOutput($sformatf("t2_ready0_%0d", i), req0_ready, p == 0);
            checkOutput($sformatf("t2_ready1_%0d", i), req1_ready, p == 1);
            step;
            checkOutput($sformatf("t2_addr_%0d", i), ram_addr, (p == 1) ? 5 : 6);
            step; step;
            checkOutput($sformatf("t2_rsp0v_%0d", i), rsp0_valid, p == 0);
            checkOutput($sformatf("t2_rsp1v_%0d", i), rsp1_valid, p == 1);
            if (p == 0) checkOutput($sformatf("t2_rdata0_%0d", i), rsp0_rdata, 8'hA6);
            else        checkOutput($sformatf("t2_rdata1_%0d", i), rsp1_rdata, 8'hA5);
        end

        // Port 1 writes 55 to addr 6 alone; next accept exactly two cycles later
        applyStimulus(0, 0, 0, 0, 1, 1, 6, 55);
        checkOutput("t3_ready1", req1_ready, 1);
        checkOutput("t3_ready0", req0_ready, 0);
        step;
        checkOutput("t3_wr_wr", ram_wr, 1);
        checkOutput("t3_wr_addr", ram_addr, 6);
        checkOutput("t3_wr_data", ram_wdata, 55);
        applyStimulus(1, 0, 6, 0, 0, 0, 0, 0);
        checkOutput("t3_issue_ready0", req0_ready, 0);
        step;
        checkOutput("t3_next_accept", req0_ready, 1);
        step;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step; step;
        checkOutput("t3_rsp0_valid", rsp0_valid, 1);
        checkOutput("t3_rsp0_rdata", rsp0_rdata, 55);

        // Reset asserted during CAPT of a port 0 read
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 0);
        checkOutput("t4_ready0", req0_ready, 1);
        step; step;
        rst = 1'b1;
        applyStimulus(1, 0, 7, 0, 1, 0, 5, 0);
        step;
        checkOutput("t4_rsp0_valid", rsp0_valid, 0);
        checkOutput("t4_rsp0_rdata", rsp0_rdata, 0);
        checkOutput("t4_ram_en", ram_en, 0);
        checkOutput("t4_ram_addr", ram_addr, 0);
        checkOutput("t4_ready0", req0_ready, 0);
        checkOutput("t4_ready1", req1_ready, 0);
        step;
        checkOutput("t4_rsp0_valid_b", rsp0_valid, 0);
        rst = 1'b0;
        #1;
        checkOutput("t4_after_ready0", req0_ready, 1);
        checkOutput("t4_after_ready1", req1_ready, 0);
        step;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_rd_addr", ram_addr, 7);
        step; step;
        checkOutput("t4_rsp0_valid_c", rsp0_valid, 1);
        checkOutput("t4_rsp0_rdata_c", rsp0_rdata, 19);

        // Port 0 writes 20 to addr 5, port 1 reads it back
        applyStimulus(1, 1, 5, 20, 0, 0, 0, 0);
        checkOutput("t5_ready0", req0_ready, 1);
        step;
        applyStimulus(0, 0, 0, 0, 1, 0, 5, 0);
        checkOutput("t5_issue_ready1", req1_ready, 0);
        step;
        checkOutput("t5_ready1", req1_ready, 1);
        step;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step; step;
        checkOutput("t5_rsp1_valid", rsp1_valid, 1);
        checkOutput("t5_rsp1_rdata", rsp1_rdata, 20);
        checkOutput("t5_rsp0_valid", rsp0_valid, 0);
        checkOutput("t5_rsp0_rdata", rsp0_rdata, 19);

`ifdef RAM_ARB_STATS_EN
        // Grant counters saturate after 300 port 0 accepts
        rst = 1'b1;
        step;
        checkOutput("st_rst_cnt0", gnt_cnt0, 0);
        checkOutput("st_rst_cnt1", gnt_cnt1, 0);
        rst = 1'b0;
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
        repeat (300) begin
            step; step;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("st_cnt0_sat", gnt_cnt0, 255);
        checkOutput("st_cnt1_zero", gnt_cnt1, 0);
        rst = 1'b1;
        step;
        checkOutput("st_clr_cnt0", gnt_cnt0, 0);
        checkOutput("st_clr_cnt1", gnt_cnt1, 0);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port 8x8 RAM (en/wr/address/data_in/data_out, 1-cycle registered read). Accepts read/write commands from two requesters over valid/ready, drives exactly one RAM access at a time, and returns read data to the owning requester with a one-cycle response strobe. Sits between the requesting datapath blocks and the RAM instance.

## Interface
- AW, 3, RAM address width
- DW, 8, RAM data width
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  command valid, port 0 / 1
- req0_ready / req1_ready  out  1  command accepted this cycle (combinational)
- req0_wr / req1_wr  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AW  command address
- req0_wdata / req1_wdata  in  DW  write data
- rsp0_valid / rsp1_valid  out  1  read data valid, one-cycle pulse
- rsp0_rdata / rsp1_rdata  out  DW  read data, held until next response on that port
- ram_en  out  1  RAM enable, registered
- ram_wr  out  1  RAM write, registered
- ram_addr  out  AW  RAM address, registered
- ram_wdata  out  DW  RAM write data, registered
- ram_rdata  in  DW  RAM data_out

## Operation
- FSM states: IDLE, ISSUE, CAPT.
- IDLE: arbiter picks one valid port; that port's ready = 1; accept = valid & ready. On accept: latch wr/addr/wdata/port id into command register, go to ISSUE. No valid: stay IDLE.
- Round robin: last_gnt register, reset 1 (port 0 wins first). Both valid -> grant port != last_gnt; one valid -> grant it. last_gnt updates only on accept.
- ISSUE: ram_en = 1, ram_wr/ram_addr/ram_wdata from command register. Write -> IDLE. Read -> CAPT.
- CAPT: ram_en = 0; sample ram_rdata at the edge ending CAPT into rspN_rdata of the owning port, pulse rspN_valid next cycle; go to IDLE.
- ready is 0 in ISSUE, CAPT, and while rst = 1. Non-granted port never sees ready.
- Requesters must hold valid and command stable until accepted; no bypass, no queuing beyond the single command register.
- Address wrap: none; AW bits used as-is.

## Timing
- Reset values: req*_ready 0, rsp*_valid 0, rsp*_rdata 0, ram_en 0, ram_wr 0, ram_addr 0, ram_wdata 0, state IDLE, last_gnt 1.
- Write: accept cycle T, ram_en = 1 with write in T+1, next accept possible in T+2.
- Read: accept T, ram_en = 1 read in T+1, RAM data valid in T+2 (CAPT), rspN_valid = 1 in T+3. Next accept possible in T+3 (overlaps response cycle).
- Reset mid-operation: pending command dropped, no RAM access or response after the reset edge; ram_en 0 from the first edge sampling rst = 1.
- rsp of the other port never pulses; simultaneous rsp0_valid and rsp1_valid impossible.

## Configuration
- RAM_ARB_STATS_EN defined: outputs gnt_cnt0, gnt_cnt1 (8 bits each), incremented on each accept for that port, saturating at 255, reset 0.
- Undefined: counters and ports absent; all other behaviour identical.

## Structure
- Package ram_arb_pkg: state enum typedef (IDLE, ISSUE, CAPT), default AW/DW constants, counter width constant (8).
- Sub-module rr_arb2: 2-way round-robin picker (inputs req0/req1/last_gnt, outputs gnt0/gnt1); FSM, command register, response logic stay in ram_arbiter.

## Test plan
- Port 0 writes 19 to addr 7, then reads addr 7 -> ram_en/ram_wr/ram_addr = 1/1/7 one cycle after accept; rsp0_valid pulses with rsp0_rdata = 19 three cycles after read accept; rsp1_valid stays 0.
- Both ports hold valid reads (addr 6, addr 5) after reset -> port 0 granted first, then port 1; alternation continues for 4 back-to-back commands each.
- Port 1 writes 55 to addr 6 while port 0 idle -> port 1 granted immediately; next accept of any port exactly two cycles later.
- Assert rst during CAPT of port 0 read -> no rsp0_valid, all outputs at reset values next cycle, next accept goes to port 0.
- Read never-written address after write 20 to addr 5, read addr 5 from port 1 -> rsp1_rdata = 20; port 0 rdata unchanged.
- With RAM_ARB_STATS_EN: 300 port-0 accepts -> gnt_cnt0 = 255, gnt_cnt1 = 0; reset clears both.
